mem_port_arbiter: RTL

Two-to-one arbiter that shares one `slow_memory` block port between the I-cache and D-cache miss/write-back interfaces of `CHIP`. It sits between the chip's `mem_*_I` / `mem_*_D` ports and a single unified memory (or the L2 fill port). It serialises whole 128-bit block transactions with round-robin fairness and counts completed transactions per port.

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-to-one round-robin arbiter sharing one block-memory port between the
// I-cache and D-cache miss/write-back interfaces, with per-port completion counters.
module mem_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,

  output logic [CNT_W-1:0]  cnt_i,
  output logic [CNT_W-1:0]  cnt_d,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester raises read and/or write with address and wdata and
  // holds them stable until it sees its ready high for one cycle; that cycle is
  // the completion. Dropping both read and write before ready aborts the request.
  // Downstream uses the same contract, with mem_ready as the completion strobe.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    GAP   = 2'd3
  } state_e;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  side_e            last_q, last_d;
  logic [CNT_W-1:0] cnt_i_q, cnt_i_d;
  logic [CNT_W-1:0] cnt_d_q, cnt_d_d;

  logic i_req;
  logic d_req;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_i_d   = cnt_i_q;
    cnt_d_d   = cnt_d_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie the side that did not complete last wins.
        if (i_req && d_req) begin
          state_d = (last_q == SIDE_D) ? GNT_I : GNT_D;
        end else if (i_req) begin
          state_d = GNT_I;
        end else if (d_req) begin
          state_d = GNT_D;
        end
      end

      GNT_I: begin
        mem_read  = i_read & ~i_write;
        mem_write = i_write;
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
        if (mem_ready) begin
          i_ready = 1'b1;
          last_d  = SIDE_I;
          if (cnt_i_q != {CNT_W{1'b1}}) begin
            cnt_i_d = cnt_i_q + CNT_ONE;
          end
          state_d = GAP;
        end else if (!i_req) begin
          state_d = IDLE;
        end
      end

      GNT_D: begin
        mem_read  = d_read & ~d_write;
        mem_write = d_write;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        if (mem_ready) begin
          d_ready = 1'b1;
          last_d  = SIDE_D;
          if (cnt_d_q != {CNT_W{1'b1}}) begin
            cnt_d_d = cnt_d_q + CNT_ONE;
          end
          state_d = GAP;
        end else if (!d_req) begin
          state_d = IDLE;
        end
      end

      GAP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= SIDE_D;
      cnt_i_q <= '0;
      cnt_d_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_i_q <= cnt_i_d;
      cnt_d_q <= cnt_d_d;
    end
  end

  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign cnt_i     = cnt_i_q;
  assign cnt_d     = cnt_d_q;
  assign dbg_state = state_q;

endmodule
